// File: rtl/vend_pay_sched.sv
// vend_pay_sched: two-channel coin FIFO scheduler in front of the cola core.
// Ports: sys_clk, sys_rst_n (sync, active-low); a_*/b_* coin pulses;
//   pi_cola/pi_change core replies; po_money_* coins to the core;
//   cola/change/drop/timeout pulses per channel; sold_cnt; sticky sync_err.
module vend_pay_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        a_half,
  input  logic        a_one,
  input  logic        b_half,
  input  logic        b_one,
  input  logic        pi_cola,
  input  logic        pi_change,
  output logic        po_money_half,
  output logic        po_money_one,
  output logic        cola_a,
  output logic        cola_b,
  output logic        change_a,
  output logic        change_b,
  output logic        drop_a,
  output logic        drop_b,
  output logic        timeout_a,
  output logic        timeout_b,
  output logic [15:0] sold_cnt,
  output logic        sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // index 0 is channel A, index 1 is channel B
  logic [1:0] coin_h, coin_o;
  assign coin_h = {b_half, a_half};
  assign coin_o = {b_one, a_one};

  logic [FIFO_DEPTH-1:0] mem_q [2];
  logic [FIFO_DEPTH-1:0] mem_d [2];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          fav_q, fav_d;
  logic          phase_q, phase_d;
  logic          xchg_q, xchg_d;
  logic [2:0]    credit_q, credit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          po_half_q, po_half_d;
  logic          po_one_q, po_one_d;
  logic [1:0]    cola_q, cola_d;
  logic [1:0]    chg_q, chg_d;
  logic [1:0]    drop_q, drop_d;
  logic [1:0]    tout_q, tout_d;
  logic [15:0]   sold_q, sold_d;
  logic          err_q, err_d;

  logic [1:0] ne, full, vld, push, pop;
  logic       do_pop, pop_ch, head;
  logic [2:0] sum;

  assign ne   = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign full = {cnt_q[1] == FULL, cnt_q[0] == FULL};
  assign vld  = coin_h ^ coin_o;
  assign pop  = {do_pop & pop_ch, do_pop & ~pop_ch};
  // a full FIFO still takes a coin when its head leaves this cycle
  assign push   = vld & (~full | pop);
  assign drop_d = (coin_h & coin_o) | (vld & full & ~pop);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    fav_d    = fav_q;
    phase_d  = phase_q;
    xchg_d   = xchg_q;
    credit_d = credit_q;
    idle_d   = idle_q;
    gap_d    = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    po_half_d = 1'b0;
    po_one_d  = 1'b0;
    cola_d = '0;
    chg_d  = '0;
    tout_d = '0;
    sold_d = sold_q;
    err_d  = err_q;
    do_pop = 1'b0;
    pop_ch = owner_q;
    head   = 1'b0;
    sum    = credit_q;
    unique case (state_q)
      S_IDLE: begin
        if (gap_q == '0 && ne != '0) begin
          pop_ch  = (&ne) ? fav_q : ne[1];
          owner_d = pop_ch;
          do_pop  = 1'b1;
          state_d = S_SERVE;
          idle_d  = '0;
        end
      end
      S_SERVE: begin
        if (ne[owner_q]) begin
          if (gap_q == '0) begin
            do_pop = 1'b1;
            idle_d = '0;
          end
        end else if (idle_q == IDLE_LAST) begin
          // credit stays: the core still holds it
          tout_d[owner_q] = 1'b1;
          fav_d   = ~owner_q;
          state_d = S_IDLE;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      S_WAIT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          cola_d[owner_q] = pi_cola;
          chg_d[owner_q]  = pi_change;
          if (pi_cola) sold_d = sold_q + 16'd1;
          if (!pi_cola || pi_change != xchg_q) err_d = 1'b1;
          fav_d   = ~owner_q;
          phase_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // core replies are only legal in the sampling phase
    if (!(state_q == S_WAIT && phase_q) && (pi_cola || pi_change))
      err_d = 1'b1;
    if (do_pop) begin
      head      = mem_q[pop_ch][rp_q[pop_ch]];
      po_one_d  = head;
      po_half_d = ~head;
      gap_d     = GAP_LD;
      sum       = credit_q + (head ? 3'd2 : 3'd1);
      if (sum >= 3'd5) begin
        credit_d = 3'd0;
        xchg_d   = (sum == 3'd6);
        phase_d  = 1'b0;
        state_d  = S_WAIT;
      end else begin
        credit_d = sum;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      mem_d[c] = mem_q[c];
      wp_d[c]  = wp_q[c];
      rp_d[c]  = rp_q[c];
      if (push[c]) begin
        mem_d[c][wp_q[c]] = coin_o[c];
        wp_d[c] = wp_q[c] + AW'(1);
      end
      if (pop[c]) rp_d[c] = rp_q[c] + AW'(1);
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < 2; c++) begin
        mem_q[c] <= '0;
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      fav_q     <= 1'b0;
      phase_q   <= 1'b0;
      xchg_q    <= 1'b0;
      credit_q  <= '0;
      gap_q     <= '0;
      idle_q    <= '0;
      po_half_q <= 1'b0;
      po_one_q  <= 1'b0;
      cola_q    <= '0;
      chg_q     <= '0;
      drop_q    <= '0;
      tout_q    <= '0;
      sold_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mem_q[c] <= mem_d[c];
        wp_q[c]  <= wp_d[c];
        rp_q[c]  <= rp_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      state_q   <= state_d;
      owner_q   <= owner_d;
      fav_q     <= fav_d;
      phase_q   <= phase_d;
      xchg_q    <= xchg_d;
      credit_q  <= credit_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      po_half_q <= po_half_d;
      po_one_q  <= po_one_d;
      cola_q    <= cola_d;
      chg_q     <= chg_d;
      drop_q    <= drop_d;
      tout_q    <= tout_d;
      sold_q    <= sold_d;
      err_q     <= err_d;
    end
  end

  assign po_money_half = po_half_q;
  assign po_money_one  = po_one_q;
  assign cola_a    = cola_q[0];
  assign cola_b    = cola_q[1];
  assign change_a  = chg_q[0];
  assign change_b  = chg_q[1];
  assign drop_a    = drop_q[0];
  assign drop_b    = drop_q[1];
  assign timeout_a = tout_q[0];
  assign timeout_b = tout_q[1];
  assign sold_cnt  = sold_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_vend_pay_sched.sv
// tb_vend_pay_sched: scoreboard bench for vend_pay_sched with a cola core model.
// Expected output events are queued with stimulus and popped as they appear.
module tb_vend_pay_sched;

  localparam int TO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_half = 1'b0, a_one = 1'b0, b_half = 1'b0, b_one = 1'b0;
  logic pi_cola = 1'b0, pi_change = 1'b0;
  logic po_money_half, po_money_one;
  logic cola_a, cola_b, change_a, change_b;
  logic drop_a, drop_b, timeout_a, timeout_b;
  logic [15:0] sold_cnt;
  logic sync_err;

  vend_pay_sched #(.FIFO_DEPTH(4), .GAP(2), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .a_half(a_half), .a_one(a_one), .b_half(b_half), .b_one(b_one),
    .pi_cola(pi_cola), .pi_change(pi_change),
    .po_money_half(po_money_half), .po_money_one(po_money_one),
    .cola_a(cola_a), .cola_b(cola_b),
    .change_a(change_a), .change_b(change_b),
    .drop_a(drop_a), .drop_b(drop_b),
    .timeout_a(timeout_a), .timeout_b(timeout_b),
    .sold_cnt(sold_cnt), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cola core: registered, vends at >= 2.5 yuan, change when 3 yuan
  logic [2:0] core_cr = 3'd0;
  logic [2:0] core_n;
  logic supp = 1'b0;
  assign core_n = core_cr + (po_money_one ? 3'd2 : 3'd0)
                + (po_money_half ? 3'd1 : 3'd0);
  always @(posedge clk) begin
    if (!rst_n) begin
      core_cr <= 3'd0;
      pi_cola <= 1'b0;
      pi_change <= 1'b0;
    end else begin
      pi_cola <= 1'b0;
      pi_change <= 1'b0;
      if (po_money_half || po_money_one) begin
        if (core_n >= 3'd5) begin
          core_cr <= 3'd0;
          pi_cola <= ~supp;
          pi_change <= (core_n == 3'd6);
        end else begin
          core_cr <= core_n;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] val;
    int cyc;
  } exp_t;

  exp_t coin_q[$];
  exp_t vend_q[$];
  exp_t drop_q[$];
  exp_t tout_q[$];

  localparam logic [3:0] ONE  = 4'b0001;
  localparam logic [3:0] HALF = 4'b0010;
  localparam logic [3:0] CA   = 4'b1000;
  localparam logic [3:0] CB   = 4'b0100;
  localparam logic [3:0] CBX  = 4'b0101;
  localparam logic [3:0] XA   = 4'b0010;
  localparam logic [3:0] XB   = 4'b0001;

  int n_vec = 0;
  int n_err = 0;
  int exp_sold = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] outs();
    return {po_money_half, po_money_one, cola_a, cola_b, change_a,
            change_b, drop_a, drop_b, timeout_a, timeout_b};
  endfunction

  task automatic e_coin(input logic [3:0] v, input int c);
    coin_q.push_back('{v, c});
  endtask
  task automatic e_vend(input logic [3:0] v, input int c);
    vend_q.push_back('{v, c});
    if (v[3] || v[2]) exp_sold++;
  endtask
  task automatic e_drop(input logic [3:0] v, input int c);
    drop_q.push_back('{v, c});
  endtask
  task automatic e_tout(input logic [3:0] v, input int c);
    tout_q.push_back('{v, c});
  endtask

  always @(negedge clk) begin
    if (po_money_half || po_money_one) begin
      if (coin_q.size() == 0) begin
        chk("coin_extra", {po_money_half, po_money_one}, 0);
      end else begin
        chk("coin", {po_money_half, po_money_one}, coin_q[0].val);
        if (coin_q[0].cyc >= 0) chk("coin_cyc", cyc, coin_q[0].cyc);
        void'(coin_q.pop_front());
      end
    end
    if (cola_a || cola_b || change_a || change_b) begin
      if (vend_q.size() == 0) begin
        chk("vend_extra", {cola_a, cola_b, change_a, change_b}, 0);
      end else begin
        chk("vend", {cola_a, cola_b, change_a, change_b}, vend_q[0].val);
        if (vend_q[0].cyc >= 0) chk("vend_cyc", cyc, vend_q[0].cyc);
        void'(vend_q.pop_front());
      end
    end
    if (drop_a || drop_b) begin
      if (drop_q.size() == 0) begin
        chk("drop_extra", {drop_a, drop_b}, 0);
      end else begin
        chk("drop", {drop_a, drop_b}, drop_q[0].val);
        if (drop_q[0].cyc >= 0) chk("drop_cyc", cyc, drop_q[0].cyc);
        void'(drop_q.pop_front());
      end
    end
    if (timeout_a || timeout_b) begin
      if (tout_q.size() == 0) begin
        chk("tout_extra", {timeout_a, timeout_b}, 0);
      end else begin
        chk("tout", {timeout_a, timeout_b}, tout_q[0].val);
        void'(tout_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ah, input logic ao,
                     input logic bh, input logic bo);
    a_half = ah; a_one = ao; b_half = bh; b_one = bo;
    tick();
    a_half = 1'b0; a_one = 1'b0; b_half = 1'b0; b_one = 1'b0;
  endtask

  function automatic int pend();
    return coin_q.size() + vend_q.size() + drop_q.size() + tout_q.size();
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pend() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, pend(), 0);
    repeat (3) tick();
  endtask

  task automatic status(input string tag);
    chk({tag, "_sold"}, sold_cnt, exp_sold);
    chk({tag, "_err"}, sync_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (2) tick();
    chk("rst_outs", outs(), 0);
    chk("rst_sold", sold_cnt, 0);
    chk("rst_err", sync_err, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // sale on A: issues at +2/+4/+6, cola at +8
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4); e_coin(HALF, s + 6);
    e_vend(CA, s + 8);
    drv(0, 1, 0, 0); drv(0, 1, 0, 0); drv(1, 0, 0, 0);
    drain("s1_drain", 40);
    status("s1");

    // three ones on B: cola and change together
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4); e_coin(ONE, s + 6);
    e_vend(CBX, s + 8);
    drv(0, 0, 0, 1); drv(0, 0, 0, 1); drv(0, 0, 0, 1);
    drain("s2_drain", 40);
    status("s2");

    // contention: A first, then B on favourite, then A again
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4); e_coin(HALF, s + 6);
    e_coin(ONE, s + 9); e_coin(ONE, s + 11); e_coin(HALF, s + 13);
    e_coin(HALF, s + 16); e_coin(ONE, s + 18); e_coin(ONE, s + 20);
    e_vend(CA, s + 8); e_vend(CB, s + 15); e_vend(CA, s + 22);
    drv(0, 1, 0, 1); drv(0, 1, 0, 0); drv(1, 0, 0, 0);
    drv(0, 0, 0, 1); drv(0, 0, 1, 0); drv(1, 0, 0, 0);
    drv(0, 1, 0, 0); drv(0, 1, 0, 0);
    drain("s3_drain", 60);
    status("s3");

    // overflow on B while A owns
    s = cyc;
    e_coin(HALF, s + 2); e_coin(ONE, s + 4); e_coin(ONE, s + 6);
    for (int i = 0; i < 5; i++) e_coin(HALF, s + 9 + 2 * i);
    e_vend(CA, s + 8); e_vend(CB, s + 19);
    e_drop(XB, s + 6);
    drv(1, 0, 0, 0); drv(0, 1, 1, 0); drv(0, 1, 1, 0);
    drv(0, 0, 1, 0); drv(0, 0, 1, 0); drv(0, 0, 1, 0);
    repeat (3) tick();
    drv(0, 0, 1, 0);
    drain("s4_drain", 60);
    status("s4");

    // illegal double pulse
    s = cyc;
    e_drop(XA, s + 1);
    drv(1, 1, 0, 0);
    drain("s5_drain", 20);

    // timeout keeps credit; B finishes the sale
    s = cyc;
    e_coin(HALF, s + 2);
    e_tout(XA, -1);
    drv(1, 0, 0, 0);
    drain("s6_drain", TO + 100);
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4);
    e_vend(CB, s + 6);
    drv(0, 0, 0, 1); drv(0, 0, 0, 1);
    drain("s7_drain", 40);
    status("s7");

    // core withholds cola once
    supp = 1'b1;
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4); e_coin(HALF, s + 6);
    drv(0, 1, 0, 0); drv(0, 1, 0, 0); drv(1, 0, 0, 0);
    drain("s8_drain", 40);
    repeat (3) tick();
    supp = 1'b0;
    chk("s8_err", sync_err, 1);
    chk("s8_sold", sold_cnt, exp_sold);

    // reset while serving
    s = cyc;
    e_coin(HALF, s + 2);
    drv(1, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_outs", outs(), 0);
    chk("mrst_sold", sold_cnt, 0);
    chk("mrst_err", sync_err, 0);
    chk("mrst_pend", pend(), 0);
    tick();
    rst_n = 1'b1;
    exp_sold = 0;
    repeat (2) tick();

    // sale after reset
    s = cyc;
    e_coin(ONE, s + 2); e_coin(ONE, s + 4); e_coin(HALF, s + 6);
    e_vend(CB, s + 8);
    drv(0, 0, 0, 1); drv(0, 0, 0, 1); drv(0, 0, 1, 0);
    drain("s9_drain", 40);
    status("s9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
